// File: rtl/y86_stage_sequencer.sv
// Multi-cycle control sequencer for the Y86-64 SEQ datapath.
// Walks each instruction through fetch, decode, execute, memory, writeback and
// PC-update, issuing one-cycle stage enables decoded from the state register.
// Tracks the Y86 status code and counts retired instructions.
module y86_stage_sequencer #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       icode,
   input  logic             imem_error,
   input  logic             dmem_ready,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             pc_en,
   output logic [2:0]       stat,
   output logic             busy,
   output logic [CNT_W-1:0] instr_count
);

   // Y86 status codes
   localparam logic [2:0] StatAok = 3'd1;
   localparam logic [2:0] StatHlt = 3'd2;
   localparam logic [2:0] StatAdr = 3'd3;
   localparam logic [2:0] StatIns = 3'd4;

   // Highest legal icode (popq)
   localparam logic [3:0] IcodeMax = 4'hB;
   localparam logic [3:0] IcodeHalt = 4'h0;

   // Wait-cycle limit in MEMORY; the counter is wide enough for 1..255
   localparam logic [7:0] TmoLimit = 8'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExecute,
      StMemory,
      StWriteback,
      StPcupdate,
      StHalted
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       icode_q, icode_d;
   logic [7:0]       tmo_q, tmo_d;
   logic [2:0]       stat_q, stat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Instructions that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq
   function automatic logic needs_mem(input logic [3:0] ic);
      return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
   endfunction

   // Instructions that write the register file (rsp updates included)
   function automatic logic writes_reg(input logic [3:0] ic);
      return ic inside {4'h2, 4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
   endfunction

   // State and bookkeeping registers; reset abandons any in-flight instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         icode_q <= 4'h0;
         tmo_q   <= 8'd0;
         stat_q  <= StatAok;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         icode_q <= icode_d;
         tmo_q   <= tmo_d;
         stat_q  <= stat_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, status and counter logic
   always_comb begin
      state_d = state_q;
      icode_d = icode_q;
      tmo_d   = 8'd0;  // only MEMORY keeps a non-zero count, so entry always sees 0
      stat_d  = stat_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFetch;
            end
         end

         StFetch: begin
            icode_d = icode;
            if (imem_error) begin
               stat_d  = StatAdr;
               state_d = StHalted;
            end else if (icode > IcodeMax) begin
               stat_d  = StatIns;
               state_d = StHalted;
            end else if (icode == IcodeHalt) begin
               // halt retires as an instruction
               stat_d  = StatHlt;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = StHalted;
            end else begin
               state_d = StDecode;
            end
         end

         StDecode: begin
            state_d = StExecute;
         end

         StExecute: begin
            state_d = needs_mem(icode_q) ? StMemory : StWriteback;
         end

         StMemory: begin
            // ready is checked first so it wins over a coincident timeout
            if (dmem_ready) begin
               if (dmem_error) begin
                  stat_d  = StatAdr;
                  state_d = StHalted;
               end else begin
                  state_d = StWriteback;
               end
            end else if ((tmo_q + 8'd1) == TmoLimit) begin
               stat_d  = StatAdr;
               state_d = StHalted;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         StWriteback: begin
            state_d = StPcupdate;
         end

         StPcupdate: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = start ? StFetch : StIdle;
         end

         StHalted: begin
            state_d = StHalted;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Moore stage enables decoded from the state register
   always_comb begin
      fetch_en   = 1'b0;
      decode_en  = 1'b0;
      execute_en = 1'b0;
      mem_en     = 1'b0;
      wb_en      = 1'b0;
      pc_en      = 1'b0;
      busy       = 1'b1;

      unique case (state_q)
         StFetch:     fetch_en   = 1'b1;
         StDecode:    decode_en  = 1'b1;
         StExecute:   execute_en = 1'b1;
         StMemory:    mem_en     = 1'b1;
         // cmov suppression happens in the datapath, not here
         StWriteback: wb_en      = writes_reg(icode_q);
         StPcupdate:  pc_en      = 1'b1;
         StIdle:      busy       = 1'b0;
         StHalted:    busy       = 1'b0;
         default:     busy       = 1'b0;
      endcase
   end

   assign stat        = stat_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed testbench for y86_stage_sequencer with hand-computed expectations.
module tb_y86_stage_sequencer;

   localparam logic [5:0] EnN = 6'b000000;
   localparam logic [5:0] EnF = 6'b100000;
   localparam logic [5:0] EnD = 6'b010000;
   localparam logic [5:0] EnE = 6'b001000;
   localparam logic [5:0] EnM = 6'b000100;
   localparam logic [5:0] EnW = 6'b000010;
   localparam logic [5:0] EnP = 6'b000001;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  icode;
   logic        imem_error;
   logic        dmem_ready;
   logic        dmem_error;
   logic        fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en;
   logic [2:0]  stat;
   logic        busy;
   logic [31:0] instr_count;
   logic [5:0]  en;

   logic        start4;
   logic        fetch4, decode4, execute4, mem4, wb4, pc4;
   logic [2:0]  stat4;
   logic        busy4;
   logic [3:0]  count4;
   logic [5:0]  en4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign en  = {fetch_en, decode_en, execute_en, mem_en, wb_en, pc_en};
   assign en4 = {fetch4, decode4, execute4, mem4, wb4, pc4};

   y86_stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .icode       (icode),
      .imem_error  (imem_error),
      .dmem_ready  (dmem_ready),
      .dmem_error  (dmem_error),
      .fetch_en    (fetch_en),
      .decode_en   (decode_en),
      .execute_en  (execute_en),
      .mem_en      (mem_en),
      .wb_en       (wb_en),
      .pc_en       (pc_en),
      .stat        (stat),
      .busy        (busy),
      .instr_count (instr_count)
   );

   // Narrow-counter instance running nops only
   y86_stage_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) dut4 (
      .clk         (clk),
      .rst         (rst),
      .start       (start4),
      .icode       (4'h1),
      .imem_error  (1'b0),
      .dmem_ready  (1'b0),
      .dmem_error  (1'b0),
      .fetch_en    (fetch4),
      .decode_en   (decode4),
      .execute_en  (execute4),
      .mem_en      (mem4),
      .wb_en       (wb4),
      .pc_en       (pc4),
      .stat        (stat4),
      .busy        (busy4),
      .instr_count (count4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_en(input string tag, input logic [5:0] exp);
      step();
      check_eq(tag, 32'(en), 32'(exp));
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      start      = 1'b0;
      start4     = 1'b0;
      icode      = 4'h0;
      imem_error = 1'b0;
      dmem_ready = 1'b0;
      dmem_error = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_en", 32'(en), 32'(EnN));
      check_eq("rst_stat", 32'(stat), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_cnt", instr_count, 32'd0);
   endtask

   // Hard stop so the bench can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // OPq: five consecutive one-hot enables, no MEMORY
      do_reset();
      icode = 4'h6;
      start = 1'b1;
      expect_en("op_f", EnF);
      start = 1'b0;
      check_eq("op_busy", 32'(busy), 32'd1);
      expect_en("op_d", EnD);
      expect_en("op_e", EnE);
      expect_en("op_w", EnW);
      expect_en("op_p", EnP);
      expect_en("op_idle", EnN);
      check_eq("op_cnt", instr_count, 32'd1);
      check_eq("op_stat", 32'(stat), 32'd1);

      // mrmovq with 3 wait cycles: 9 cycles total
      do_reset();
      icode = 4'h5;
      start = 1'b1;
      expect_en("mr_f", EnF);
      start = 1'b0;
      expect_en("mr_d", EnD);
      expect_en("mr_e", EnE);
      expect_en("mr_m1", EnM);
      expect_en("mr_m2", EnM);
      expect_en("mr_m3", EnM);
      expect_en("mr_m4", EnM);
      dmem_ready = 1'b1;
      expect_en("mr_w", EnW);
      dmem_ready = 1'b0;
      expect_en("mr_p", EnP);
      expect_en("mr_idle", EnN);
      check_eq("mr_cnt", instr_count, 32'd1);

      // rmmovq: no register write
      do_reset();
      icode = 4'h4;
      start = 1'b1;
      expect_en("rm_f", EnF);
      start = 1'b0;
      expect_en("rm_d", EnD);
      expect_en("rm_e", EnE);
      expect_en("rm_m", EnM);
      dmem_ready = 1'b1;
      expect_en("rm_wb_nowrite", EnN);
      dmem_ready = 1'b0;
      check_eq("rm_busy", 32'(busy), 32'd1);
      expect_en("rm_p", EnP);

      // jXX skips MEMORY and writes nothing
      do_reset();
      icode = 4'h7;
      start = 1'b1;
      expect_en("j_f", EnF);
      start = 1'b0;
      expect_en("j_d", EnD);
      expect_en("j_e", EnE);
      expect_en("j_w", EnN);
      expect_en("j_p", EnP);

      // halt: sticky, start ignored
      do_reset();
      icode = 4'h0;
      start = 1'b1;
      expect_en("h_f", EnF);
      expect_en("h_halt", EnN);
      check_eq("h_stat", 32'(stat), 32'd2);
      check_eq("h_cnt", instr_count, 32'd1);
      check_eq("h_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         expect_en("h_sticky", EnN);
      end
      check_eq("h_stat_hold", 32'(stat), 32'd2);

      // illegal icode
      do_reset();
      icode = 4'hC;
      start = 1'b1;
      expect_en("ins_f", EnF);
      start = 1'b0;
      expect_en("ins_halt", EnN);
      check_eq("ins_stat", 32'(stat), 32'd4);
      check_eq("ins_cnt", instr_count, 32'd0);

      // nop back-to-back, then imem fault on second fetch
      do_reset();
      icode = 4'h1;
      start = 1'b1;
      expect_en("im_f1", EnF);
      expect_en("im_d1", EnD);
      expect_en("im_e1", EnE);
      expect_en("im_w1", EnN);
      expect_en("im_p1", EnP);
      expect_en("im_f2", EnF);
      imem_error = 1'b1;
      start = 1'b0;
      expect_en("im_halt", EnN);
      imem_error = 1'b0;
      check_eq("im_stat", 32'(stat), 32'd3);
      check_eq("im_cnt", instr_count, 32'd1);

      // MEMORY timeout after 15 cycles
      do_reset();
      icode = 4'h5;
      start = 1'b1;
      expect_en("to_f", EnF);
      start = 1'b0;
      expect_en("to_d", EnD);
      expect_en("to_e", EnE);
      for (int i = 0; i < 15; i++) begin
         expect_en("to_m", EnM);
      end
      expect_en("to_halt", EnN);
      check_eq("to_stat", 32'(stat), 32'd3);
      check_eq("to_busy", 32'(busy), 32'd0);

      // ready in the final allowed cycle beats the timeout
      do_reset();
      icode = 4'h5;
      start = 1'b1;
      expect_en("rw_f", EnF);
      start = 1'b0;
      expect_en("rw_d", EnD);
      expect_en("rw_e", EnE);
      for (int i = 0; i < 15; i++) begin
         expect_en("rw_m", EnM);
      end
      dmem_ready = 1'b1;
      expect_en("rw_w", EnW);
      dmem_ready = 1'b0;
      expect_en("rw_p", EnP);
      expect_en("rw_idle", EnN);
      check_eq("rw_stat", 32'(stat), 32'd1);
      check_eq("rw_cnt", instr_count, 32'd1);

      // dmem error
      do_reset();
      icode = 4'h9;
      start = 1'b1;
      expect_en("de_f", EnF);
      start = 1'b0;
      expect_en("de_d", EnD);
      expect_en("de_e", EnE);
      expect_en("de_m", EnM);
      dmem_ready = 1'b1;
      dmem_error = 1'b1;
      expect_en("de_halt", EnN);
      dmem_ready = 1'b0;
      dmem_error = 1'b0;
      check_eq("de_stat", 32'(stat), 32'd3);
      check_eq("de_cnt", instr_count, 32'd0);

      // asynchronous reset in the middle of MEMORY
      do_reset();
      icode = 4'h1;
      start = 1'b1;
      expect_en("ar_f1", EnF);
      expect_en("ar_d1", EnD);
      expect_en("ar_e1", EnE);
      expect_en("ar_w1", EnN);
      expect_en("ar_p1", EnP);
      icode = 4'h5;
      expect_en("ar_f2", EnF);
      start = 1'b0;
      expect_en("ar_d2", EnD);
      expect_en("ar_e2", EnE);
      expect_en("ar_m", EnM);
      check_eq("ar_cnt_pre", instr_count, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("ar_en", 32'(en), 32'(EnN));
      check_eq("ar_stat", 32'(stat), 32'd1);
      check_eq("ar_cnt", instr_count, 32'd0);
      check_eq("ar_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      expect_en("ar_after", EnN);
      expect_en("ar_after2", EnN);

      // 4-bit counter wraps after 16 back-to-back nops
      do_reset();
      start4 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         check_eq("w_f", 32'(en4), 32'(EnF));
         check_eq("w_cnt", 32'(count4), i);
         step();
         check_eq("w_d", 32'(en4), 32'(EnD));
         step();
         check_eq("w_e", 32'(en4), 32'(EnE));
         step();
         check_eq("w_w", 32'(en4), 32'(EnN));
         step();
         check_eq("w_p", 32'(en4), 32'(EnP));
      end
      step();
      check_eq("w_f_last", 32'(en4), 32'(EnF));
      check_eq("w_wrap", 32'(count4), 32'd0);
      check_eq("w_stat", 32'(stat4), 32'd1);
      start4 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_stage_sequencer.md
Name: y86_stage_sequencer

Overview:
- Multi-cycle control FSM for the Y86-64 SEQ datapath. Steps each instruction through fetch, decode, execute, memory, writeback and PC-update.
- Issues one-cycle enables per stage and gates the register-file write clock-enable (writes only for icodes that update registers).
- Waits on a data-memory ready handshake, with a timeout.
- Maintains the Y86 status code and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter
- MEM_TIMEOUT, 15, maximum cycles spent in MEMORY waiting for dmem_ready before an ADR fault (range 1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  level; leave IDLE and begin fetching
- icode  input  4  instruction code from fetch, valid while fetch_en is high
- imem_error  input  1  fetch address fault, sampled with fetch_en
- dmem_ready  input  1  data memory access complete, sampled in MEMORY
- dmem_error  input  1  data memory address fault, sampled with dmem_ready
- fetch_en  output  1  latch fetched instruction fields
- decode_en  output  1  read register file (valA/valB)
- execute_en  output  1  ALU/condition evaluation
- mem_en  output  1  data memory request, held high through MEMORY
- wb_en  output  1  register-file write strobe
- pc_en  output  1  PC register update
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  output  1  high in any state other than IDLE/HALTED
- instr_count  output  CNT_W  retired instructions

Behaviour:
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALTED. Registered (Moore) outputs are decoded from the state.
- Reset (async, immediate on any state):
  - state=IDLE, all enables 0, stat=1 (AOK), busy=0, instr_count=0.
  - The icode latch and timeout counter clear to 0.
  - Reset mid-instruction abandons that instruction; no wb_en or pc_en is issued.
- IDLE: when start=1, go to FETCH; otherwise stay.
- FETCH:
  - fetch_en=1 for exactly one cycle; icode is latched internally.
  - If imem_error=1: stat<=3, go to HALTED.
  - Else if icode>4'hB: stat<=4, go to HALTED.
  - Else if icode=0 (halt): stat<=2, instr_count+=1, go to HALTED.
  - Otherwise go to DECODE.
- DECODE: decode_en=1 for one cycle, then EXECUTE.
- EXECUTE: execute_en=1 for one cycle.
  - Next state is MEMORY for latched icode in {4,5,8,9,A,B}.
  - Otherwise next state is WRITEBACK (icodes 1,2,3,6,7 skip MEMORY).
- MEMORY:
  - mem_en=1 each cycle in the state. The timeout counter starts at 0 on entry and increments each cycle dmem_ready=0.
  - dmem_ready=1 && dmem_error=0: go to WRITEBACK.
  - dmem_ready=1 && dmem_error=1: stat<=3, go to HALTED.
  - Counter reaching MEM_TIMEOUT with dmem_ready still 0: stat<=3, go to HALTED.
  - dmem_ready=1 in the same cycle the counter would reach MEM_TIMEOUT: ready wins.
  - Minimum residency 1 cycle (ready on the first cycle).
- WRITEBACK:
  - One cycle; wb_en=1 only for icode in {2,3,5,6,8,9,A,B}.
  - The cmov condition is applied in the datapath, not here.
  - Then PCUPDATE.
- PCUPDATE:
  - pc_en=1 for one cycle; instr_count+=1, wrapping modulo 2^CNT_W.
  - If start=1, go to FETCH; else go to IDLE.
- HALTED:
  - Sticky; all enables 0, busy=0, stat holds.
  - Only rst leaves HALTED; start is ignored.
- Latency:
  - Non-memory instruction: 5 cycles, FETCH to PCUPDATE inclusive.
  - Memory instruction: 6+k cycles, where k is the number of wait cycles.
- Invariant: at most one of fetch_en/decode_en/execute_en/wb_en/pc_en is high in any cycle; mem_en is never high alongside another enable.
- stat stays 1 until a fault or halt; it never returns to 1 without rst.

Test Plan:
- Reset, start=1, icode=6 (OPq) with no faults → fetch_en, decode_en, execute_en, wb_en, pc_en each high for one cycle on consecutive cycles, mem_en never high, instr_count=1, stat=1.
- icode=5 (mrmovq), dmem_ready asserted after 3 wait cycles → mem_en high 4 cycles, wb_en=1, pc_en follows, 9 cycles total, instr_count=1.
- icode=4 (rmmovq) → wb_en stays 0 in WRITEBACK.
- icode=7 (jXX) → MEMORY skipped, wb_en=0, pc_en=1.
- icode=0 → stat=2, instr_count=1, HALTED with busy=0; start held high produces no further fetch_en.
- icode=4'hC → stat=4.
- imem_error=1 → stat=3, instr_count unchanged.
- MEMORY with dmem_ready held 0 and MEM_TIMEOUT=15 → stat=3 after 15 cycles.
- MEMORY with dmem_ready=1 and dmem_error=1 → stat=3.
- rst asserted mid-MEMORY → state IDLE the same cycle, all enables 0, stat=1, instr_count=0.
- CNT_W=4, 16 back-to-back nops with start held → instr_count wraps to 0, and every PCUPDATE leads directly to FETCH.
